// File: rtl/serial_adder_16_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, nibble width
// and the nibble-count helper.
package serial_adder_16_pkg;

   localparam int unsigned NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Nibble cycles needed for an operand of the given width.
   function automatic int unsigned num_nibbles(input int unsigned width);
      return width / NIB_W;
   endfunction

endpackage

// File: rtl/serial_adder_16_nibble_add.sv
// Combinational 4-bit adder stage, time-shared across all nibbles of an operation.
module nibble_add
   import serial_adder_16_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             ci,
   output logic [NIB_W-1:0] s,
   output logic             co
);

   assign {co, s} = (NIB_W+1)'(a) + (NIB_W+1)'(b) + (NIB_W+1)'(ci);

endmodule

// File: rtl/serial_adder_16.sv
// Nibble-serial unsigned adder: x+y+cin computed LSB nibble first, one nibble per cycle.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_16
   import serial_adder_16_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned N     = num_nibbles(WIDTH);
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   x_q, x_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               c_q, c_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic [NIB_W-1:0]   nib_a, nib_b, nib_s;
   logic               nib_co;

   // Current nibble of each captured operand feeds the shared adder stage.
   assign nib_a = x_q[NIB_W*int'(cnt_q) +: NIB_W];
   assign nib_b = y_q[NIB_W*int'(cnt_q) +: NIB_W];

   nibble_add u_nibble_add (
      .a  (nib_a),
      .b  (nib_b),
      .ci (c_q),
      .s  (nib_s),
      .co (nib_co)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      c_d     = c_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = x;
               y_d     = y;
               c_d     = cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[NIB_W*int'(cnt_q) +: NIB_W] = nib_s;
            c_d   = nib_co;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N-1)) begin
               cnt_d   = '0;
               carry_d = nib_co;
`ifdef SERIAL_ADDER_OVF_EN
               // Carry into the MSB is recovered from the MSB sum bit and its inputs.
               ovf_d   = nib_co ^ (nib_s[NIB_W-1] ^ nib_a[NIB_W-1] ^ nib_b[NIB_W-1]);
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered views of the next state.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_16.sv
// Scoreboard bench for serial_adder_16 (WIDTH=16): driver pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder_16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] x, y;
   logic        cin;
   logic        busy, done, carry;
   logic [15:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;
   logic [17:0] exp_q[$];   // {ovf, carry, sum}

   always #5 clk = ~clk;

   serial_adder_16 #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .y     (y),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .carry (carry)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      if (busy !== 1'b0) chk("wait_idle_timeout", 32'(busy), 32'd0);
   endtask

   // Reference: plain wide arithmetic, overflow from operand/result signs.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic ci);
      logic [16:0] r;
      logic        ov;
      r  = {1'b0, a} + {1'b0, b} + 17'(ci);
      ov = (a[15] == b[15]) && (r[15] != a[15]);
      return {ov, r};
   endfunction

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci);
      logic [17:0] e;
      wait_idle();
      e = model(a, b, ci);
      exp_q.push_back(e);
      start = 1'b1; x = a; y = b; cin = ci;
      tick();
      start = 1'b0;
      x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom);
      for (int k = 1; k <= 5; k++) begin
         chk("busy_run", 32'(busy), 32'd1);
         chk("done_timing", 32'(done), 32'(k == 5));
         if (k < 5) tick();
      end
      tick();
      chk("busy_idle", 32'(busy), 32'd0);
      chk("done_idle", 32'(done), 32'd0);
      tick();
      tick();
      chk("sum_hold", 32'(sum), 32'(e[15:0]));
      chk("carry_hold", 32'(carry), 32'(e[16]));
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [17:0] e;
      if (rst === 1'b0 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sum", 32'(sum), 32'(e[15:0]));
            chk("carry", 32'(carry), 32'(e[16]));
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf", 32'(ovf), 32'(e[17]));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b1; x = 16'hFFFF; y = 16'hFFFF; cin = 1'b1;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_carry", 32'(carry), 32'd0);
      rst = 1'b0; start = 1'b0;
      tick();
      chk("idle_after_rst", 32'(busy), 32'd0);

      run_op(16'h1234, 16'h4321, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0);
      run_op(16'hFFFF, 16'h0000, 1'b1);
      run_op(16'h7FFF, 16'h0001, 1'b0);
      run_op(16'h8000, 16'h8000, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 25; i++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom));

      // start held high: second op only accepted in the IDLE cycle after DONE.
      wait_idle();
      exp_q.push_back(model(16'h0001, 16'h0001, 1'b0));
      start = 1'b1; x = 16'h0001; y = 16'h0001; cin = 1'b0;
      tick();
      x = 16'h1111; y = 16'h2222;
      for (int k = 0; k < 4; k++) tick();
      chk("held_done", 32'(done), 32'd1);
      exp_q.push_back(model(16'h1111, 16'h2222, 1'b0));
      tick();
      chk("held_idle_gap", 32'(busy), 32'd0);
      tick();
      chk("held_reaccept", 32'(busy), 32'd1);
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("held_second_done", 32'(done), 32'd1);
      tick();
      wait_idle();

      // Reset on the 3rd RUN edge discards the operation.
      start = 1'b1; x = 16'hAAAA; y = 16'h5555; cin = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_carry", 32'(carry), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("abort_ovf", 32'(ovf), 32'd0);
`endif
      for (int k = 0; k < 10; k++) tick();

      run_op(16'hAAAA, 16'h5555, 1'b1);
      tick();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder_16.md
SERIAL_ADDER_16 -- requirements
Module: serial_adder_16

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Port: clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: x  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 Port: y  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 Port: cin  input  1  carry-in, captured on the accepting edge.
REQ-008 Port: busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 Port: done  output  1  single-cycle pulse; result valid.
REQ-010 Port: sum  output  WIDTH  result bits.
REQ-011 Port: carry  output  1  carry-out of the MSB nibble.

Function
REQ-012 The block SHALL add x+y+cin one nibble per cycle, LSB nibble first, through a 4-bit adder stage; N = WIDTH/4 nibble cycles.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE with start=1: capture x, y, cin, clear nibble counter to 0, go to RUN.
REQ-015 IDLE with start=0: stay in IDLE; sum and carry hold their last values.
REQ-016 Each RUN edge: add nibble[cnt] of x and y with the running carry, write the 4-bit result into sum[4*cnt+3:4*cnt], store the nibble carry-out as the running carry, cnt+1.
REQ-017 RUN with cnt=N-1: after the write, load carry with the final carry and go to DONE.
REQ-018 DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-019 Latency: done SHALL be high in the cycle following the (N+1)th rising edge, counting the accepting edge as the first (WIDTH=16: 5 edges).
REQ-020 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-021 start in RUN or DONE SHALL be ignored; it is not queued, and operands are not re-sampled.
REQ-022 sum and carry SHALL be intermediate during RUN; they are valid when done=1 and stay stable in IDLE until the next accepted start.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH, with carry = bit WIDTH of x+y+cin; wrap-around (e.g. all-ones + 1) SHALL give sum=0, carry=1.
REQ-024 Back-to-back: start may be accepted in the IDLE cycle immediately after DONE; the minimum issue interval is N+2 cycles.

Reset
REQ-025 When rst=1 on an edge: state=IDLE, cnt=0, busy=0, done=0, sum=0, carry=0, and internal operand/carry registers are cleared.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 rst asserted during RUN or DONE SHALL discard the in-flight operation; no done pulse SHALL follow.

Configuration
REQ-028 Macro SERIAL_ADDER_OVF_EN defined: an extra output port ovf (output, 1 bit) SHALL be present, giving signed two's-complement overflow (carry into MSB XOR carry out of MSB); it is updated with carry, reset to 0, and valid under the same rules as carry.
REQ-029 Macro SERIAL_ADDER_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-030 The shared package SHALL hold the FSM state enum (IDLE/RUN/DONE), the nibble width constant (4), and the function computing N from WIDTH.
REQ-031 One sub-module, nibble_add (4-bit a, b, ci -> 4-bit s, co, combinational), SHALL be instantiated once and time-shared across nibbles.

Verification (WIDTH=16)
REQ-032 x=0x1234, y=0x4321, cin=0, start pulse -> done high 5 edges later, sum=0x5555, carry=0, busy high for 5 cycles.
REQ-033 x=0xFFFF, y=0x0001, cin=0 -> sum=0x0000, carry=1 (carry ripples through all 4 nibbles); also x=0xFFFF, y=0x0000, cin=1 -> sum=0x0000, carry=1.
REQ-034 start held high continuously, first op x=0x0001, y=0x0001 -> second op captured only in the IDLE cycle after DONE; operand changes during RUN do not affect the result 0x0002.
REQ-035 rst=1 on the 3rd RUN edge of x=0xAAAA, y=0x5555 -> next cycle busy=0, done=0, sum=0, carry=0; no done pulse follows.
REQ-036 With SERIAL_ADDER_OVF_EN: x=0x7FFF, y=0x0001 -> sum=0x8000, carry=0, ovf=1; x=0xFFFF, y=0x0001 -> ovf=0, carry=1.
